// File: rtl/lif_spike_monitor.sv
// Spike-rate and inter-spike-interval monitor for a LIF neuron output.
// Counts rising edges over back-to-back windows and reports ISI per edge.
module lif_spike_monitor #(
  parameter int unsigned WIN_W = 16,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ISI_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_count,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam logic [WIN_W-1:0] WinOne = WIN_W'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [ISI_W-1:0] IsiOne = ISI_W'(1);
  localparam logic [ISI_W-1:0] IsiMax = '1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] t_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ISI_W-1:0] isi_cnt_q;
  logic             spike_prev;
  logic             seen_q;

  logic             spike_edge;
  logic             in_idle;
  logic             win_active;
  logic             win_last;
  logic             win_done;
  logic [WIN_W-1:0] cur_len;
  logic [WIN_W-1:0] cur_t;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] cnt_sum;
  logic [ISI_W-1:0] isi_sum;

  // The cycle that leaves idle is window cycle 0, so idle presents a virtual
  // window start (t=0, cnt=0, len=window_len) to the shared datapath.
  always_comb begin
    spike_edge = spike_in & ~spike_prev;
    in_idle    = (state_q == StIdle);
    win_active = en & (~in_idle | (window_len != '0));
    cur_len    = in_idle ? window_len : len_q;
    cur_t      = in_idle ? '0 : t_q;
    cur_cnt    = in_idle ? '0 : cnt_q;
    cnt_sum    = (spike_edge && (cur_cnt != CntMax)) ? cur_cnt + CntOne : cur_cnt;
    win_last   = (cur_t == cur_len - WinOne);
    win_done   = win_active & win_last;
    isi_sum    = (isi_cnt_q != IsiMax) ? isi_cnt_q + IsiOne : isi_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      t_q        <= '0;
      cnt_q      <= '0;
      isi_cnt_q  <= '0;
      spike_prev <= 1'b0;
      seen_q     <= 1'b0;
      rate_count <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
    end else begin
      spike_prev <= spike_in;
      isi_valid  <= 1'b0;

      // Window sequencing
      if (!en) begin
        state_q <= StIdle;
        t_q     <= '0;
        cnt_q   <= '0;
      end else if (win_active) begin
        if (win_last) begin
          state_q <= (window_len != '0) ? StRun : StIdle;
          len_q   <= window_len;
          t_q     <= '0;
          cnt_q   <= '0;
        end else begin
          state_q <= StRun;
          len_q   <= cur_len;
          t_q     <= cur_t + WinOne;
          cnt_q   <= cnt_sum;
        end
      end

      // Single-entry result register; a completion always wins over a drain.
      if (win_done) begin
        rate_count <= cnt_sum;
        rate_valid <= 1'b1;
        if (rate_valid && !rate_ready) begin
          overrun <= 1'b1;
        end
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end

      // Inter-spike interval
      if (!en) begin
        isi_cnt_q <= '0;
        seen_q    <= 1'b0;
      end else if (spike_edge) begin
        if (seen_q) begin
          isi       <= isi_sum;
          isi_valid <= 1'b1;
        end
        isi_cnt_q <= '0;
        seen_q    <= 1'b1;
      end else begin
        isi_cnt_q <= isi_sum;
      end
    end
  end

endmodule
